// File: rtl/seq_bin2bcd_ctrl_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADJ_THRESH  = 5;

endpackage

// File: rtl/seq_bin2bcd_ctrl_if.sv
// Request/result bundle between a conversion requester and the converter.
interface seq_bin2bcd_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );

endinterface

// File: rtl/seq_bin2bcd_ctrl_dabble_digit.sv
// One double-dabble digit adjuster: adds 3 to a BCD digit of 5 or more.
// Digits entering here are always <= 9, so the 4-bit sum never wraps.
module bcd_dabble_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  localparam logic [BCD_DIGIT_W-1:0] THRESH = BCD_DIGIT_W'(ADJ_THRESH);
  localparam logic [BCD_DIGIT_W-1:0] BIAS   = BCD_DIGIT_W'(3);

  // Conditional +3 so the following left shift produces a valid BCD carry.
  always_comb begin
    adjusted = digit;
    if (digit >= THRESH) begin
      adjusted = digit + BIAS;
    end
  end

endmodule

// File: rtl/seq_bin2bcd_ctrl.sv
// Multi-cycle shift-and-add-3 binary-to-BCD converter with start/done handshake.
// One bank of digit adjusters is reused over WIDTH shift cycles.
module seq_bin2bcd_ctrl
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_bin2bcd_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;

  state_t            state;
  state_t            next_state;
  logic [SR_W-1:0]   shreg;
  logic [SR_W-1:0]   adjusted;
  logic [CNT_W-1:0]  count;
  logic              sticky;
  logic              done_q;
  logic [BCD_W-1:0]  bcd_q;
  logic              overflow_q;

  // Adjust every BCD digit in parallel; the binary field passes through untouched.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_dabble_digit u_digit (
      .digit    (shreg[WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (adjusted[WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign adjusted[WIDTH-1:0] = shreg[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: SHIFT runs until the counter's last step, FINISH lasts one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = SHIFT;
      SHIFT:   if (count == CNT_W'(1)) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shift register, counter, sticky overflow and the registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      count      <= '0;
      sticky     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= (state == FINISH);
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg  <= {{BCD_W{1'b0}}, bus.bin_in};
            count  <= CNT_W'(WIDTH);
            sticky <= 1'b0;
          end
        end
        SHIFT: begin
          shreg <= {adjusted[SR_W-2:0], 1'b0};
          count <= count - CNT_W'(1);
          if (adjusted[SR_W-1]) begin
            sticky <= 1'b1;
          end
        end
        FINISH: begin
          bcd_q      <= shreg[SR_W-1 -: BCD_W];
          overflow_q <= sticky;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy     = (state == SHIFT);
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_seq_bin2bcd_ctrl.sv
// Self-checking bench: a 3-digit and a 2-digit converter run side by side
// against a decimal-arithmetic reference model.
module tb_seq_bin2bcd_ctrl;

  logic clk;
  logic rst_n;

  int checks;
  int passes;

  seq_bin2bcd_ctrl_if #(.WIDTH(8), .DIGITS(3)) if3 ();
  seq_bin2bcd_ctrl_if #(.WIDTH(8), .DIGITS(2)) if2 ();

  seq_bin2bcd_ctrl #(.WIDTH(8), .DIGITS(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3.slave)
  );

  seq_bin2bcd_ctrl #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.slave)
  );

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Decimal digits of v, ones in [3:0].
  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] d0, d1, d2;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    return {d2, d1, d0};
  endfunction

  // Behavioural BCD-to-binary path used for the round trip.
  function automatic int bcd_to_bin(input logic [11:0] b);
    int ones, tens, hund;
    ones = int'(b[3:0]);
    tens = int'(b[7:4]);
    hund = int'(b[11:8]);
    return hund * 100 + tens * 10 + ones;
  endfunction

  // Requester side: both converters get identical requests.
  task automatic drive(input logic s, input logic [7:0] v);
    if3.start  = s;
    if3.bin_in = v;
    if2.start  = s;
    if2.bin_in = v;
  endtask

  // Issue one request at a negedge and wait (bounded) for done; returns on the done negedge.
  task automatic convert(input logic [7:0] v, output int lat, output int busy_cnt, output bit seen);
    drive(1'b1, v);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'($urandom));
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (lat < 30 && !seen) begin
      if (if3.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (if3.busy === 1'b1) busy_cnt++;
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 8'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if3.busy, if3.done, if3.overflow} !== 3'b000) $display("[TB] FAIL reset_flags3: got %b expected 000", {if3.busy, if3.done, if3.overflow});
    else passes++;
    checks++;
    if (if3.bcd_out !== 12'h000) $display("[TB] FAIL reset_bcd3: got %h expected 000", if3.bcd_out);
    else passes++;
    checks++;
    if ({if2.busy, if2.done, if2.overflow, if2.bcd_out} !== 11'd0) $display("[TB] FAIL reset_dut2: got %h expected 000", {if2.busy, if2.done, if2.overflow, if2.bcd_out});
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat, bc;
    bit seen;
    convert(8'd0, lat, bc, seen);
    checks++;
    if (lat !== 9) $display("[TB] FAIL zero_latency: got %0d expected 9", lat);
    else passes++;
    checks++;
    if (bc !== 8) $display("[TB] FAIL zero_busy_cycles: got %0d expected 8", bc);
    else passes++;
    checks++;
    if ({if3.overflow, if3.bcd_out} !== 13'h0000) $display("[TB] FAIL zero_result: got %h expected 0000", {if3.overflow, if3.bcd_out});
    else passes++;
    @(negedge clk);
    checks++;
    if (if3.done !== 1'b0) $display("[TB] FAIL zero_done_width: got %b expected 0", if3.done);
    else passes++;
  endtask

  // Convert v on both DUTs and compare against the decimal model.
  task automatic check_value(input logic [7:0] v, input string tag);
    int lat, bc;
    bit seen;
    logic [11:0] exp3;
    logic [7:0]  exp2;
    exp3 = ref_bcd(int'(v));
    exp2 = exp3[7:0];
    convert(v, lat, bc, seen);
    checks++;
    if (!seen) $display("[TB] FAIL %s_timeout: done not seen for %0d", tag, v);
    else passes++;
    checks++;
    if ({if3.overflow, if3.bcd_out} !== {1'b0, exp3}) $display("[TB] FAIL %s_bcd3 (%0d): got %b/%h expected 0/%h", tag, v, if3.overflow, if3.bcd_out, exp3);
    else passes++;
    checks++;
    if ({if2.overflow, if2.bcd_out} !== {(v > 8'd99), exp2}) $display("[TB] FAIL %s_bcd2 (%0d): got %b/%h expected %b/%h", tag, v, if2.overflow, if2.bcd_out, (v > 8'd99), exp2);
    else passes++;
    checks++;
    if (bcd_to_bin(if3.bcd_out) !== int'(v)) $display("[TB] FAIL %s_roundtrip: got %0d expected %0d", tag, bcd_to_bin(if3.bcd_out), v);
    else passes++;
  endtask

  task automatic test_corners();
    check_value(8'd255, "corner");
    check_value(8'd99,  "corner");
    check_value(8'd100, "corner");
    check_value(8'd9,   "corner");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      check_value(8'($urandom), "random");
    end
  endtask

  // Results hold while idle and are not cleared by a new request.
  task automatic test_hold();
    logic [7:0]  a;
    logic [11:0] exp_a;
    int n;
    a = 8'($urandom_range(150, 250));
    exp_a = ref_bcd(int'(a));
    check_value(a, "hold_first");
    repeat (3) @(negedge clk);
    checks++;
    if (if3.bcd_out !== exp_a) $display("[TB] FAIL hold_idle: got %h expected %h", if3.bcd_out, exp_a);
    else passes++;
    drive(1'b1, 8'd37);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'd200);
    repeat (3) @(negedge clk);
    checks++;
    if (if3.bcd_out !== exp_a) $display("[TB] FAIL hold_during_conv: got %h expected %h", if3.bcd_out, exp_a);
    else passes++;
    n = 0;
    while (n < 30 && if3.done !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (if3.bcd_out !== 12'h037) $display("[TB] FAIL hold_late_bin_in: got %h expected 037", if3.bcd_out);
    else passes++;
  endtask

  // start held high with bin_in changing each cycle: only every 10th value is taken.
  task automatic test_back_to_back();
    logic [7:0]  vals [0:39];
    logic [11:0] exp3;
    logic [7:0]  exp2;
    bit exp_done;
    for (int i = 0; i < 40; i++) vals[i] = 8'($urandom);
    @(negedge clk);
    drive(1'b1, vals[0]);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      exp_done = (n % 10 == 0);
      checks++;
      if (if3.done !== exp_done) $display("[TB] FAIL b2b_done cycle %0d: got %b expected %b", n, if3.done, exp_done);
      else passes++;
      if (exp_done) begin
        exp3 = ref_bcd(int'(vals[n-10]));
        exp2 = exp3[7:0];
        checks++;
        if (if3.bcd_out !== exp3) $display("[TB] FAIL b2b_bcd3 cycle %0d: got %h expected %h", n, if3.bcd_out, exp3);
        else passes++;
        checks++;
        if ({if2.overflow, if2.bcd_out} !== {(vals[n-10] > 8'd99), exp2}) $display("[TB] FAIL b2b_bcd2 cycle %0d: got %b/%h expected %b/%h", n, if2.overflow, if2.bcd_out, (vals[n-10] > 8'd99), exp2);
        else passes++;
      end
      if (n < 40) drive(1'b1, vals[n]);
      else drive(1'b0, 8'd0);
    end
    repeat (12) @(negedge clk);
  endtask

  // Reset mid-conversion aborts silently; the next conversion is clean.
  task automatic test_reset_abort();
    int dones;
    check_value(8'd173, "abort_pre");
    drive(1'b1, 8'd137);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if3.busy, if3.done, if3.overflow, if3.bcd_out} !== 15'd0) $display("[TB] FAIL abort_outputs: got %h expected 0000", {if3.busy, if3.done, if3.overflow, if3.bcd_out});
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (if3.done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) $display("[TB] FAIL abort_no_done: got %0d expected 0", dones);
    else passes++;
    check_value(8'd42, "abort_post");
  endtask

  // Full-range back-to-back sweep through the round trip.
  task automatic test_sweep();
    for (int v = 0; v < 256; v++) begin
      check_value(8'(v), "sweep");
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n  = 1'b1;
    drive(1'b0, 8'd0);
    @(negedge clk);
    test_reset();
    test_zero();
    test_corners();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
